// File: rtl/gshare_idx_ctrl.sv
// gshare_idx_ctrl: gshare PC^GHR indexing, in-order lookup FIFO and PHT counter write-back.
// Optional statistics counters are enabled by defining BP_STATS_EN.
`default_nettype none

module gshare_idx_ctrl #(
    parameter int IDX_W      = 14,
    parameter int PC_W       = 32,
    parameter int PC_LSB     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_ready,
    output logic             pout_valid,
    output logic             pout_taken,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             res_ready,
    output logic             mispredict,
    output logic [IDX_W-1:0] pht_addr,
    output logic             pht_wr_en,
    output logic [1:0]       pht_wr_data,
    input  logic [1:0]       pht_rd_data
`ifdef BP_STATS_EN
    ,
    output logic [31:0]      stat_lookups,
    output logic [31:0]      stat_mispred
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] ghr;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             pop;
    logic [CNT_W:0]   occ;

    logic             lkp_v_q;
    logic [IDX_W-1:0] lkp_idx_q;

    logic             upd_v_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic [1:0]       upd_cnt_q;
    logic             upd_mis_q;

    logic [IDX_W-1:0] fifo_idx [FIFO_DEPTH];
    logic [1:0]       fifo_cnt [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0] head_idx;
    logic [1:0]       head_cnt;
    logic [1:0]       new_cnt;

    logic             unused_pc;
    assign unused_pc = ^pred_pc;

    assign idx        = pred_pc[PC_LSB +: IDX_W] ^ ghr;
    assign occ        = {1'b0, count} + {{CNT_W{1'b0}}, lkp_v_q};
    // The write-back owns the PHT port, so lookups stall during a write cycle.
    assign pred_ready = !upd_v_q && (occ < (CNT_W+1)'(FIFO_DEPTH));
    assign accept     = pred_valid && pred_ready;
    assign res_ready  = (count != '0);
    assign pop        = res_valid && res_ready;

    assign head_idx = fifo_idx[rd_ptr];
    assign head_cnt = fifo_cnt[rd_ptr];

    always_comb begin
        new_cnt = head_cnt;
        if (res_taken) begin
            if (head_cnt != 2'b11) new_cnt = head_cnt + 2'b01;
        end else begin
            if (head_cnt != 2'b00) new_cnt = head_cnt - 2'b01;
        end
    end

    assign pout_valid  = lkp_v_q;
    assign pout_taken  = lkp_v_q && pht_rd_data[1];
    assign pht_wr_en   = upd_v_q;
    assign pht_wr_data = upd_v_q ? upd_cnt_q : 2'b00;
    assign mispredict  = upd_v_q && upd_mis_q;

    always_comb begin
        pht_addr = '0;
        if (upd_v_q)     pht_addr = upd_idx_q;
        else if (accept) pht_addr = idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr       <= '0;
            lkp_v_q   <= 1'b0;
            lkp_idx_q <= '0;
            upd_v_q   <= 1'b0;
            upd_idx_q <= '0;
            upd_cnt_q <= 2'b00;
            upd_mis_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            lkp_v_q <= accept;
            if (accept) lkp_idx_q <= idx;
            upd_v_q <= pop;
            if (pop) begin
                upd_idx_q <= head_idx;
                upd_cnt_q <= new_cnt;
                upd_mis_q <= head_cnt[1] ^ res_taken;
                ghr       <= {ghr[IDX_W-2:0], res_taken};
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (lkp_v_q) wr_ptr <= wr_ptr + 1'b1;
            if (lkp_v_q && !pop)      count <= count + 1'b1;
            else if (!lkp_v_q && pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (lkp_v_q) begin
            fifo_idx[wr_ptr] <= lkp_idx_q;
            fifo_cnt[wr_ptr] <= pht_rd_data;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else begin
            if (accept)     stat_lookups <= stat_lookups + 32'd1;
            if (mispredict) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire
